// File: rtl/tanh_lane_scheduler_if.sv
// Job and core-side signals of the tanh lane scheduler.
// The scheduler is the slave. The surrounding datapath and the tanh core act as the master.
// Handshake: a job request is start=1 in a cycle where the scheduler is IDLE or DONE, and it is
// taken at that clock edge. The core is released while core_reset=0. The core reports a result by
// holding core_done=1 with core_out valid in the same cycle. A request made while busy is dropped.
interface tanh_lane_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 16
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic                    start;
  logic [N*DATA_WIDTH-1:0] x;
  logic [DATA_WIDTH-1:0]   core_x;
  logic                    core_reset;
  logic [DATA_WIDTH-1:0]   core_out;
  logic                    core_done;
  logic [N*DATA_WIDTH-1:0] Output;
  logic                    FinishedTanh;
  logic                    busy;
  logic                    timeout_err;
  logic [IDX_W-1:0]        lane_idx;

  modport master (
    output start, x, core_out, core_done,
    input  core_x, core_reset, Output, FinishedTanh, busy, timeout_err, lane_idx
  );

  modport slave (
    input  start, x, core_out, core_done,
    output core_x, core_reset, Output, FinishedTanh, busy, timeout_err, lane_idx
  );
endinterface

// File: rtl/tanh_lane_scheduler.sv
// Shares one tanh core across an N-lane packed float vector, one lane at a time.
// Lane 0 sits in the MSBs of both x and Output.
module tanh_lane_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                 clk,
  input  logic                 resetExternal,
  tanh_lane_scheduler_if.slave bus,
  output logic [1:0]           state_dbg
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [DATA_WIDTH-1:0]   x_lane   [N];
  logic [DATA_WIDTH-1:0]   xreg     [N];
  logic [DATA_WIDTH-1:0]   out_lane [N];
  logic [N*DATA_WIDTH-1:0] out_packed;
  logic [IDX_W-1:0]        lane_idx;
  logic [CNT_W-1:0]        run_cnt;
  logic [DATA_WIDTH-1:0]   core_x_q;
  logic                    timeout_err_q;
  logic                    accept;
  logic                    lane_wr;
  logic                    lane_to;
  logic                    last_lane;

  // Unpack the input vector and pack the result vector, lane 0 in the MSBs.
  for (genvar g = 0; g < N; g++) begin : g_lane
    assign x_lane[g] = bus.x[(N-g)*DATA_WIDTH-1 -: DATA_WIDTH];
    assign out_packed[(N-g)*DATA_WIDTH-1 -: DATA_WIDTH] = out_lane[g];
  end

  assign last_lane = (lane_idx == IDX_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (resetExternal) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the accept and lane-write strobes. core_done only matters in RUN, and it
  // takes priority over the timeout so a late but valid result is kept.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    lane_wr   = 1'b0;
    lane_to   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        if (bus.core_done) begin
          lane_wr = 1'b1;
        end else if (run_cnt == CNT_LAST) begin
          lane_wr = 1'b1;
          lane_to = 1'b1;
        end
        if (lane_wr) begin
          state_nxt = last_lane ? DONE : LOAD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Job datapath: latch on accept, present the operand in LOAD, count and write back in RUN.
  always_ff @(posedge clk) begin
    if (resetExternal) begin
      xreg          <= '{default: '0};
      out_lane      <= '{default: '0};
      lane_idx      <= '0;
      run_cnt       <= '0;
      core_x_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (accept) begin
        xreg          <= x_lane;
        out_lane      <= '{default: '0};
        timeout_err_q <= 1'b0;
        lane_idx      <= '0;
      end
      if (state == LOAD) begin
        core_x_q <= xreg[lane_idx];
        run_cnt  <= '0;
      end
      if (state == RUN && !lane_wr) begin
        run_cnt <= run_cnt + CNT_W'(1);
      end
      if (lane_wr) begin
        out_lane[lane_idx] <= lane_to ? '0 : bus.core_out;
        if (lane_to) begin
          timeout_err_q <= 1'b1;
        end
        if (!last_lane) begin
          lane_idx <= lane_idx + IDX_W'(1);
        end
      end
    end
  end

  assign bus.core_x       = core_x_q;
  assign bus.core_reset   = (state != RUN);
  assign bus.Output       = out_packed;
  assign bus.FinishedTanh = (state == DONE);
  assign bus.busy         = (state == LOAD) || (state == RUN);
  assign bus.timeout_err  = timeout_err_q;
  assign bus.lane_idx     = lane_idx;
  assign state_dbg        = state;
endmodule

// File: tb/tb_tanh_lane_scheduler.sv
// Bench for tanh_lane_scheduler. It runs two instances: a 2-lane one with TIMEOUT=8 and a
// 16-lane one with TIMEOUT=1024. Each instance has its own tanh core model with a settable latency.
module tb_tanh_lane_scheduler;
  localparam int DW  = 32;
  localparam int NA  = 2;
  localparam int TOA = 8;
  localparam int NB  = 16;
  localparam int TOB = 1024;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  tanh_lane_scheduler_if #(.DATA_WIDTH(DW), .N(NA)) bus_a ();
  tanh_lane_scheduler_if #(.DATA_WIDTH(DW), .N(NB)) bus_b ();
  logic [1:0] state_a;
  logic [1:0] state_b;

  tanh_lane_scheduler #(.DATA_WIDTH(DW), .N(NA), .TIMEOUT(TOA)) dut_a (
    .clk(clk), .resetExternal(rst), .bus(bus_a), .state_dbg(state_a)
  );
  tanh_lane_scheduler #(.DATA_WIDTH(DW), .N(NB), .TIMEOUT(TOB)) dut_b (
    .clk(clk), .resetExternal(rst), .bus(bus_b), .state_dbg(state_b)
  );

  // ---------------- tanh core models ----------------
  // The core function: two fixed tanh points, and everything else maps to v ^ 16'hFFFF.
  function automatic logic [DW-1:0] tanh_ref(input logic [DW-1:0] v);
    case (v)
      32'h3F19999A: return 32'h3F096F7B;
      32'h40400000: return 32'h3F800000;
      default:      return v ^ 32'h0000FFFF;
    endcase
  endfunction

  int            lat_a;
  int            lat_b;
  int            run_a;
  int            run_b;
  bit            hang_a;
  logic [DW-1:0] hang_x_a;

  always @(posedge clk) run_a <= bus_a.core_reset ? 0 : run_a + 1;
  always @(posedge clk) run_b <= bus_b.core_reset ? 0 : run_b + 1;

  // The model asserts done in the lat-th cycle after the core leaves reset. A hung operand never finishes.
  assign bus_a.core_done = !bus_a.core_reset && (run_a == lat_a - 1) &&
                           !(hang_a && bus_a.core_x == hang_x_a);
  assign bus_a.core_out  = bus_a.core_done ? tanh_ref(bus_a.core_x) : 32'hDEADBEEF;
  assign bus_b.core_done = !bus_b.core_reset && (run_b == lat_b - 1);
  assign bus_b.core_out  = bus_b.core_done ? tanh_ref(bus_b.core_x) : 32'hDEADBEEF;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int checks;
  int errors;

  function automatic logic [DW-1:0] lane_of_a(input logic [NA*DW-1:0] v, input int i);
    logic [NA*DW-1:0] t;
    t = v >> ((NA - 1 - i) * DW);
    return t[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] lane_of_b(input logic [NB*DW-1:0] v, input int i);
    logic [NB*DW-1:0] t;
    t = v >> ((NB - 1 - i) * DW);
    return t[DW-1:0];
  endfunction

  // Job-level model of the 2-lane instance. A lane gets the core result after lat+1 cycles.
  // A lane that never finishes, or finishes later than TIMEOUT, is written as 0 after TIMEOUT+1 cycles.
  task automatic model_job_a(input logic [NA*DW-1:0] xv, output int exp_edges, output bit exp_err);
    exp_edges = 0;
    exp_err   = 1'b0;
    for (int i = 0; i < NA; i++) begin
      logic [DW-1:0] xi;
      xi = lane_of_a(xv, i);
      if ((hang_a && xi == hang_x_a) || lat_a > TOA) begin
        exp_q.push_back('0);
        exp_edges += TOA + 1;
        exp_err = 1'b1;
      end else begin
        exp_q.push_back(tanh_ref(xi));
        exp_edges += lat_a + 1;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents start with x and returns right after the accept edge. start is left high.
  task automatic start_job_a(input logic [NA*DW-1:0] xv);
    @(negedge clk);
    bus_a.start = 1'b1;
    bus_a.x     = xv;
    @(posedge clk);
  endtask

  task automatic start_job_b(input logic [NB*DW-1:0] xv);
    @(negedge clk);
    bus_b.start = 1'b1;
    bus_b.x     = xv;
    @(posedge clk);
  endtask

  // Counts clock edges after the accept edge until FinishedTanh is seen, within a bounded budget.
  task automatic wait_finish_a(output int edges, output bit seen);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 400) begin
      @(posedge clk);
      edges++;
      #1;
      if (bus_a.FinishedTanh === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_finish_b(output int edges, output bit seen);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 400) begin
      @(posedge clk);
      edges++;
      #1;
      if (bus_b.FinishedTanh === 1'b1) seen = 1'b1;
    end
  endtask

  // Runs one job on the 2-lane instance and checks the accept, the latency, the error flag and every lane.
  task automatic run_job_check_a(input string tag, input logic [NA*DW-1:0] xv);
    int            exp_edges;
    int            edges;
    bit            exp_err;
    bit            seen;
    logic [DW-1:0] exp_l;
    logic [DW-1:0] got_l;
    model_job_a(xv, exp_edges, exp_err);
    start_job_a(xv);
    @(negedge clk);
    bus_a.start = 1'b0;
    checks++;
    if (bus_a.busy !== 1'b1 || bus_a.FinishedTanh !== 1'b0 || bus_a.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept busy=%b fin=%b terr=%b required busy=1 fin=0 terr=0",
               tag, bus_a.busy, bus_a.FinishedTanh, bus_a.timeout_err);
    end
    wait_finish_a(edges, seen);
    checks++;
    if (!seen || edges != exp_edges) begin
      errors++;
      $display("FAIL %s_latency got %0d edges (seen=%b) required %0d", tag, edges, seen, exp_edges);
    end
    checks++;
    if (bus_a.timeout_err !== exp_err) begin
      errors++;
      $display("FAIL %s_timeout_err got %b required %b", tag, bus_a.timeout_err, exp_err);
    end
    for (int i = 0; i < NA; i++) begin
      exp_l = exp_q.pop_front();
      got_l = lane_of_a(bus_a.Output, i);
      checks++;
      if (got_l !== exp_l) begin
        errors++;
        $display("FAIL %s_lane%0d got %h required %h", tag, i, got_l, exp_l);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bit bad;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus_a.core_reset !== 1'b1 || bus_a.FinishedTanh !== 1'b0 || bus_a.busy !== 1'b0 ||
        bus_a.timeout_err !== 1'b0 || bus_a.lane_idx !== '0 || bus_a.core_x !== '0 ||
        bus_a.Output !== '0) begin
      errors++;
      $display("FAIL reset_a cr=%b fin=%b busy=%b terr=%b idx=%h cx=%h out=%h required 1 0 0 0 0 0 0",
               bus_a.core_reset, bus_a.FinishedTanh, bus_a.busy, bus_a.timeout_err,
               bus_a.lane_idx, bus_a.core_x, bus_a.Output);
    end
    checks++;
    if (bus_b.core_reset !== 1'b1 || bus_b.FinishedTanh !== 1'b0 || bus_b.busy !== 1'b0 ||
        bus_b.Output !== '0 || bus_b.lane_idx !== '0) begin
      errors++;
      $display("FAIL reset_b cr=%b fin=%b busy=%b idx=%h required 1 0 0 0, Output zero",
               bus_b.core_reset, bus_b.FinishedTanh, bus_b.busy, bus_b.lane_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus_a.core_reset !== 1'b1 || bus_a.FinishedTanh !== 1'b0 || bus_a.busy !== 1'b0 ||
          bus_a.Output !== '0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL idle_hold got cr=%b fin=%b busy=%b required cr=1 fin=0 busy=0 out=0",
               bus_a.core_reset, bus_a.FinishedTanh, bus_a.busy);
    end
  endtask

  task automatic test_known_vector();
    logic [NA*DW-1:0] out_snap;
    bit               bad;
    lat_a  = 5;
    hang_a = 1'b0;
    run_job_check_a("known", 64'h3F19999A_40400000);
    checks++;
    if (bus_a.Output !== 64'h3F096F7B_3F800000) begin
      errors++;
      $display("FAIL known_vector got %h required 3f096f7b3f800000", bus_a.Output);
    end
    checks++;
    if (bus_a.lane_idx !== 1'b1 || bus_a.core_reset !== 1'b1 || bus_a.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_state idx=%h cr=%b busy=%b required idx=1 cr=1 busy=0",
               bus_a.lane_idx, bus_a.core_reset, bus_a.busy);
    end
    out_snap = bus_a.Output;
    bad = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus_a.Output !== out_snap || bus_a.FinishedTanh !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL done_hold got out=%h fin=%b required out=%h fin=1",
               bus_a.Output, bus_a.FinishedTanh, out_snap);
    end
  endtask

  task automatic test_ramp_n16();
    logic [NB*DW-1:0] xv;
    logic [DW-1:0]    base;
    logic [DW-1:0]    exp_l;
    logic [DW-1:0]    got_l;
    int               edges;
    bit               seen;
    lat_b = 3;
    base  = $urandom;
    xv    = '0;
    for (int i = 0; i < NB; i++) begin
      xv = {xv[(NB-1)*DW-1:0], base + DW'(i)};
      exp_q.push_back(tanh_ref(base + DW'(i)));
    end
    start_job_b(xv);
    @(negedge clk);
    bus_b.start = 1'b0;
    wait_finish_b(edges, seen);
    checks++;
    if (!seen || edges != NB * (lat_b + 1)) begin
      errors++;
      $display("FAIL ramp_latency got %0d edges (seen=%b) required %0d", edges, seen, NB * (lat_b + 1));
    end
    checks++;
    if (bus_b.lane_idx !== 4'd15 || bus_b.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL ramp_done idx=%0d terr=%b required idx=15 terr=0", bus_b.lane_idx, bus_b.timeout_err);
    end
    for (int i = 0; i < NB; i++) begin
      exp_l = exp_q.pop_front();
      got_l = lane_of_b(bus_b.Output, i);
      checks++;
      if (got_l !== exp_l) begin
        errors++;
        $display("FAIL ramp_lane%0d got %h required %h", i, got_l, exp_l);
      end
    end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] h;
    // lane 1 never finishes
    h        = $urandom;
    hang_a   = 1'b1;
    hang_x_a = h;
    lat_a    = $urandom_range(1, TOA - 1);
    run_job_check_a("hang_lane1", {h ^ 32'h1, h});
    // done in the same cycle as the timeout: the result is kept and no error is raised
    hang_a = 1'b0;
    lat_a  = TOA;
    run_job_check_a("tie", {DW'($urandom), DW'($urandom)});
    // core is one cycle too slow: both lanes are abandoned
    lat_a = TOA + 1;
    run_job_check_a("late", {DW'($urandom), DW'($urandom)});
    // a normal job clears the sticky error
    lat_a = 2;
    run_job_check_a("clear", {DW'($urandom), DW'($urandom)});
  endtask

  task automatic test_reset_mid_job();
    bit bad;
    lat_a  = 5;
    hang_a = 1'b0;
    start_job_a({DW'($urandom), DW'($urandom)});
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (bus_a.busy !== 1'b1 || bus_a.core_reset !== 1'b0 || bus_a.lane_idx !== 1'b1) begin
      errors++;
      $display("FAIL mid_run busy=%b cr=%b idx=%h required busy=1 cr=0 idx=1",
               bus_a.busy, bus_a.core_reset, bus_a.lane_idx);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus_a.busy !== 1'b0 || bus_a.FinishedTanh !== 1'b0 || bus_a.Output !== '0 ||
        bus_a.core_reset !== 1'b1 || bus_a.lane_idx !== '0 || bus_a.timeout_err !== 1'b0 ||
        bus_a.core_x !== '0) begin
      errors++;
      $display("FAIL mid_reset busy=%b fin=%b out=%h cr=%b idx=%h cx=%h required all idle/zero",
               bus_a.busy, bus_a.FinishedTanh, bus_a.Output, bus_a.core_reset,
               bus_a.lane_idx, bus_a.core_x);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus_a.core_reset !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.Output !== '0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL post_reset_quiet cr=%b busy=%b out=%h required cr=1 busy=0 out=0",
               bus_a.core_reset, bus_a.busy, bus_a.Output);
    end
  endtask

  task automatic test_back_to_back();
    logic [NA*DW-1:0] x1;
    logic [NA*DW-1:0] x2;
    logic [DW-1:0]    exp_l;
    logic [DW-1:0]    got_l;
    int               exp_edges;
    int               edges;
    bit               exp_err;
    bit               seen;
    lat_a  = $urandom_range(1, 6);
    hang_a = 1'b0;
    x1 = {DW'($urandom), DW'($urandom)};
    x2 = ~x1;
    model_job_a(x1, exp_edges, exp_err);
    start_job_a(x1);
    @(negedge clk);
    bus_a.x = x2;
    wait_finish_a(edges, seen);
    checks++;
    if (!seen || edges != exp_edges) begin
      errors++;
      $display("FAIL b2b_first_latency got %0d (seen=%b) required %0d", edges, seen, exp_edges);
    end
    for (int i = 0; i < NA; i++) begin
      exp_l = exp_q.pop_front();
      got_l = lane_of_a(bus_a.Output, i);
      checks++;
      if (got_l !== exp_l) begin
        errors++;
        $display("FAIL b2b_first_lane%0d got %h required %h", i, got_l, exp_l);
      end
    end
    // start is still high, so DONE accepts the second job on the next edge
    model_job_a(x2, exp_edges, exp_err);
    @(posedge clk);
    #1;
    checks++;
    if (bus_a.FinishedTanh !== 1'b0 || bus_a.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept fin=%b busy=%b required fin=0 busy=1", bus_a.FinishedTanh, bus_a.busy);
    end
    @(negedge clk);
    bus_a.start = 1'b0;
    wait_finish_a(edges, seen);
    checks++;
    if (!seen || edges != exp_edges) begin
      errors++;
      $display("FAIL b2b_second_latency got %0d (seen=%b) required %0d", edges, seen, exp_edges);
    end
    for (int i = 0; i < NA; i++) begin
      exp_l = exp_q.pop_front();
      got_l = lane_of_a(bus_a.Output, i);
      checks++;
      if (got_l !== exp_l) begin
        errors++;
        $display("FAIL b2b_second_lane%0d got %h required %h", i, got_l, exp_l);
      end
    end
  endtask

  task automatic test_random();
    logic [NA*DW-1:0] xv;
    for (int n = 0; n < 6; n++) begin
      lat_a    = $urandom_range(1, TOA + 2);
      xv       = {DW'($urandom), DW'($urandom)};
      hang_a   = ($urandom_range(0, 2) == 0);
      hang_x_a = lane_of_a(xv, $urandom_range(0, NA - 1));
      run_job_check_a($sformatf("rand%0d", n), xv);
    end
    hang_a = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus_a.start = 1'b0;
    bus_a.x     = '0;
    bus_b.start = 1'b0;
    bus_b.x     = '0;
    lat_a       = 5;
    lat_b       = 3;
    hang_a      = 1'b0;
    hang_x_a    = '0;
    test_reset();
    test_known_vector();
    test_ramp_n16();
    test_timeout();
    test_reset_mid_job();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
